uw_frame_insert: RTL and testbench

UW_FRAME_INSERT -- requirements
Module: uw_frame_insert

---
 rtl/uw_frame_insert.sv | 210 +++++++++++++++++++++
 tb/tb_uw_frame_insert.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uw_frame_insert.sv
`default_nettype none
// ============================================================================
//  Module   : uw_frame_insert
//  Purpose  : Serial burst framer. After an optional run of filler zeros it
//             emits NUM_FRAMES frames, each made of a SYNC_LEN-bit unique
//             word (chosen by rotation) followed by BITS_PER_FRAME-SYNC_LEN
//             payload bits taken from a valid/ready input stream.
//  Ports    : clk        - single clock
//             rst_in     - synchronous active-high reset
//             start      - begins a burst (only honoured in IDLE)
//             rotation   - selects the sync word, latched at start
//             bit_offset - number of leading filler bits, latched at start
//             data_in    - payload bit
//             valid_in   - data_in is valid
//             ready_out  - payload accepted this cycle (high in PAYLOAD)
//             hard_out   - registered serial output bit
//             valid_out  - hard_out is valid
//             busy       - a burst is in progress
//             done       - one-cycle pulse on the final output bit
//  Revision : 1.0 - initial release
// ============================================================================
module uw_frame_insert #(
    parameter int BITS_PER_FRAME = 80,
    parameter int NUM_FRAMES     = 32,   // must be >= 2
    parameter int SYNC_LEN       = 8     // must be <= 8
) (
    input  logic                              clk,
    input  logic                              rst_in,
    input  logic                              start,
    input  logic [1:0]                        rotation,
    input  logic [$clog2(BITS_PER_FRAME)-1:0] bit_offset,
    input  logic                              data_in,
    input  logic                              valid_in,
    output logic                              ready_out,
    output logic                              hard_out,
    output logic                              valid_out,
    output logic                              busy,
    output logic                              done
);

    localparam int BW = $clog2(BITS_PER_FRAME);
    localparam int FW = $clog2(NUM_FRAMES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_OFFSET  = 2'd1;
    localparam logic [1:0] S_SYNC    = 2'd2;
    localparam logic [1:0] S_PAYLOAD = 2'd3;

    localparam logic [BW-1:0] C_LAST_BIT   = BW'(BITS_PER_FRAME - 1);
    localparam logic [BW-1:0] C_LAST_SYNC  = BW'(SYNC_LEN - 1);
    localparam logic [FW-1:0] C_LAST_FRAME = FW'(NUM_FRAMES - 1);

    logic [1:0]    state_q,     state_d;
    logic [BW-1:0] bit_cnt_q,   bit_cnt_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]    rot_q,       rot_d;
    logic [BW-1:0] off_q,       off_d;
    logic          hard_q,      hard_d;
    logic          valid_q,     valid_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;

    logic [BW-1:0] w_off_clamped;
    logic [7:0]    w_sync_word;
    logic          w_sync_bit;
    logic          w_frame_end;
    logic          w_burst_end;

    // Offsets that would not fit in one frame saturate at a frame minus one.
    assign w_off_clamped = (32'(bit_offset) >= 32'(BITS_PER_FRAME)) ? C_LAST_BIT : bit_offset;

    always_comb begin
        unique case (rot_q)
            2'd0:    w_sync_word = 8'h27;
            2'd1:    w_sync_word = 8'h4E;
            2'd2:    w_sync_word = 8'hD8;
            default: w_sync_word = 8'hB1;
        endcase
    end

    // During SYNC the bit counter runs 0..SYNC_LEN-1, so it indexes the word MSB first.
    assign w_sync_bit = w_sync_word[3'(SYNC_LEN - 1) - bit_cnt_q[2:0]];

    // The bit counter keeps running through the payload, so the frame ends at BITS_PER_FRAME-1.
    assign w_frame_end = (state_q == S_PAYLOAD) && valid_in && (bit_cnt_q == C_LAST_BIT);
    assign w_burst_end = w_frame_end && (frame_cnt_q == C_LAST_FRAME);

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            rot_q       <= '0;
            off_q       <= '0;
            hard_q      <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            rot_q       <= rot_d;
            off_q       <= off_d;
            hard_q      <= hard_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        rot_d       = rot_q;
        off_d       = off_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rot_d       = rotation;
                    off_d       = w_off_clamped;
                    bit_cnt_d   = '0;
                    frame_cnt_d = '0;
                    state_d     = (w_off_clamped != '0) ? S_OFFSET : S_SYNC;
                end
            end
            S_OFFSET: begin
                // Filler reuses the bit counter, then restarts it for frame 0.
                if (bit_cnt_q == off_q - BW'(1)) begin
                    bit_cnt_d = '0;
                    state_d   = S_SYNC;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            S_SYNC: begin
                bit_cnt_d = bit_cnt_q + BW'(1);
                if (bit_cnt_q == C_LAST_SYNC) begin
                    state_d = S_PAYLOAD;
                end
            end
            default: begin
                if (valid_in) begin
                    if (w_frame_end) begin
                        bit_cnt_d = '0;
                        if (w_burst_end) begin
                            frame_cnt_d = '0;
                            state_d     = S_IDLE;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FW'(1);
                            state_d     = S_SYNC;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic (next values of the registered outputs)
    // ------------------------------------------------------------------------
    always_comb begin
        hard_d  = hard_q;   // hard_out holds whenever no bit is produced
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                end
            end
            S_OFFSET: begin
                hard_d  = 1'b0;
                valid_d = 1'b1;
            end
            S_SYNC: begin
                hard_d  = w_sync_bit;
                valid_d = 1'b1;
            end
            default: begin
                if (valid_in) begin
                    hard_d  = data_in;
                    valid_d = 1'b1;
                end
                if (w_burst_end) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
        endcase
    end

    assign ready_out = (state_q == S_PAYLOAD);
    assign hard_out  = hard_q;
    assign valid_out = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uw_frame_insert.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uw_frame_insert
//  Purpose  : Self-checking bench for uw_frame_insert. Expected output bits
//             are queued when a burst is launched and compared as the DUT
//             emits them; each burst also queues its expected length and gap
//             count, checked on its done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uw_frame_insert;

    localparam int BPF  = 80;
    localparam int NF   = 32;
    localparam int SL   = 8;
    localparam int PAYN = BPF - SL;
    localparam int NPAY = NF * PAYN;

    logic       clk;
    logic       rst_in;
    logic       start;
    logic [1:0] rotation;
    logic [6:0] bit_offset;
    logic       data_in;
    logic       valid_in;
    logic       ready_out;
    logic       hard_out;
    logic       valid_out;
    logic       busy;
    logic       done;

    typedef struct {
        int bits;
        int gaps;
    } mark_t;

    int    total = 0;
    int    bad   = 0;
    bit    exp_q[$];
    mark_t marks[$];
    int    burst_bits = 0;
    int    burst_gaps = 0;
    int    done_cnt   = 0;
    bit    in_burst   = 1'b0;
    bit    prev_rst   = 1'b0;
    bit    last_hard  = 1'b0;
    bit    pay [NPAY];

    uw_frame_insert #(
        .BITS_PER_FRAME (BPF),
        .NUM_FRAMES     (NF),
        .SYNC_LEN       (SL)
    ) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .start      (start),
        .rotation   (rotation),
        .bit_offset (bit_offset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .hard_out   (hard_out),
        .valid_out  (valid_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] uw(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h27;
            2'd1:    return 8'h4E;
            2'd2:    return 8'hD8;
            default: return 8'hB1;
        endcase
    endfunction

    // Output monitor, sampled on the falling edge.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (valid_out) begin
                chk("exp_avail", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("out_bit", hard_out, exp_q.pop_front());
                burst_bits++;
                in_burst = 1'b1;
            end else begin
                if (!prev_rst) chk("hold_hard", hard_out, last_hard);
                if (in_burst && busy) burst_gaps++;
            end
            if (done) begin
                chk("done_valid", valid_out, 1);
                chk("done_busy", busy, 0);
                chk("done_expected", 32'(marks.size() != 0), 1);
                if (marks.size() != 0) begin
                    mark_t m;
                    m = marks.pop_front();
                    chk("burst_len", burst_bits, m.bits);
                    chk("burst_gaps", burst_gaps, m.gaps);
                end
                done_cnt++;
                burst_bits = 0;
                burst_gaps = 0;
                in_burst   = 1'b0;
            end
            last_hard = hard_out;
            if (rst_in) begin
                exp_q.delete();
                marks.delete();
                burst_bits = 0;
                burst_gaps = 0;
                in_burst   = 1'b0;
            end
            prev_rst = rst_in;
        end
    endtask

    // Launches one burst at posedge+1 and returns at posedge+1 of the first IDLE cycle.
    task automatic run_burst(input logic [1:0] rot, input int off, input bit rnd,
                             input int gap_at, input int abort_at, input int busy_start_at);
        int         eff;
        int         pidx;
        int         gap_left;
        int         cyc;
        bit         acc;
        bit         gap_done;
        bit         bs_done;
        logic [7:0] w;
        eff = (off >= BPF) ? BPF - 1 : off;
        w   = uw(rot);
        for (int i = 0; i < NPAY; i++) pay[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int i = 0; i < eff; i++) exp_q.push_back(1'b0);
        for (int f = 0; f < NF; f++) begin
            for (int b = 7; b >= 0; b--) exp_q.push_back(w[b]);
            for (int i = 0; i < PAYN; i++) exp_q.push_back(pay[f * PAYN + i]);
        end
        if (abort_at < 0) marks.push_back('{bits: eff + NF * BPF, gaps: (gap_at >= 0) ? 3 : 0});

        start      = 1'b1;
        rotation   = rot;
        bit_offset = 7'(off);
        @(posedge clk); #1;
        start      = 1'b0;
        rotation   = ~rot;
        bit_offset = 7'd17;
        chk("busy_after_start", busy, 1);

        pidx     = 0;
        gap_left = 0;
        cyc      = 0;
        gap_done = 1'b0;
        bs_done  = 1'b0;
        while (!done && cyc < 3000) begin
            if (abort_at >= 0 && pidx == abort_at) break;
            if (gap_at >= 0 && !gap_done && pidx == gap_at) begin
                gap_left = 3;
                gap_done = 1'b1;
            end
            valid_in = (gap_left == 0);
            if (gap_left > 0) gap_left--;
            data_in = (pidx < NPAY) ? pay[pidx] : 1'b0;
            if (busy_start_at >= 0 && pidx == busy_start_at && !bs_done) begin
                start      = 1'b1;
                rotation   = 2'd1;
                bit_offset = 7'd3;
                bs_done    = 1'b1;
            end else begin
                start = 1'b0;
            end
            acc = ready_out && valid_in;
            @(posedge clk); #1;
            if (acc) pidx++;
            cyc++;
        end
        start    = 1'b0;
        valid_in = 1'b1;

        if (abort_at >= 0) begin
            chk("abort_point", pidx, abort_at);
            rst_in = 1'b1;
            @(posedge clk); #1;
            rst_in = 1'b0;
            chk("abort_valid", valid_out, 0);
            chk("abort_busy", busy, 0);
            chk("abort_ready", ready_out, 0);
            chk("abort_done", done, 0);
            repeat (20) begin
                @(posedge clk); #1;
                chk("abort_no_done", done, 0);
                chk("abort_no_valid", valid_out, 0);
            end
        end else begin
            chk("burst_done_seen", done, 1);
            chk("payload_consumed", pidx, NPAY);
        end
    endtask

    initial begin
        rst_in     = 1'b1;
        start      = 1'b0;
        rotation   = 2'd0;
        bit_offset = 7'd0;
        data_in    = 1'b0;
        valid_in   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", ready_out, 0);
        chk("rst_hard", hard_out, 0);

        // Reset must win over a simultaneous start.
        start    = 1'b1;
        rotation = 2'd2;
        @(posedge clk); #1;
        chk("rst_prio_busy", busy, 0);
        chk("rst_prio_ready", ready_out, 0);
        start  = 1'b0;
        rst_in = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        fork
            monitor();
        join_none

        run_burst(2'd0, 0, 1'b0, -1, -1, -1);   // all-ones payload, no offset
        run_burst(2'd2, 5, 1'b1, -1, -1, 300);  // back-to-back, offset 5, start while busy
        run_burst(2'd1, 10, 1'b1, 308, -1, -1); // 3-cycle valid_in gap in frame 4
        run_burst(2'd3, 90, 1'b1, -1, -1, -1);  // offset clamps to 79
        run_burst(2'd0, 0, 1'b1, -1, 752, -1);  // reset at frame 10 bit 40
        run_burst(2'd1, 3, 1'b1, -1, -1, -1);   // clean burst after abort

        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_cnt, 5);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
